// File: rtl/tetris_pkg.sv
// ============================================================================
// Module      : tetris_pkg
// Description : Shared geometry, palette codes and pixel classes for the
//               Tetris playfield renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tetris_pkg;

    localparam int c_board_x0  = 220;
    localparam int c_board_y0  = 40;
    localparam int c_cell_px   = 20;
    localparam int c_cols      = 10;
    localparam int c_rows      = 20;
    localparam int c_frame_px  = 4;

    // Reciprocal of 20 scaled by 2^12; exact for offsets 0..399.
    localparam int c_div_mul   = 205;
    localparam int c_div_shift = 12;

    localparam int c_col_w     = 4;
    localparam int c_row_w     = 5;
    localparam int c_sub_w     = 5;
    localparam int c_addr_w    = 8;

    localparam logic [3:0] c_color_empty = 4'h0;
    localparam logic [3:0] c_color_grid  = 4'hc;
    localparam logic [3:0] c_color_edge  = 4'hd;
    localparam logic [3:0] c_color_frame = 4'he;
    localparam logic [3:0] c_color_bg    = 4'hf;

    typedef enum logic [1:0] {
        PIX_BG    = 2'd0,
        PIX_FRAME = 2'd1,
        PIX_CELL  = 2'd2
    } pixel_class_t;

endpackage

`default_nettype wire

// File: rtl/tetris_cell_locator.sv
// ============================================================================
// Module      : tetris_cell_locator
// Description : Combinational mapping of a screen pixel onto playfield cell,
//               in-cell offset and frame-ring membership.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_cell_locator
    import tetris_pkg::*;
#(
    parameter int BOARD_X0 = c_board_x0,
    parameter int BOARD_Y0 = c_board_y0,
    parameter int CELL_PX  = c_cell_px,
    parameter int COLS     = c_cols,
    parameter int ROWS     = c_rows,
    parameter int FRAME_PX = c_frame_px
) (
    input  logic [9:0]         i_draw_x,
    input  logic [9:0]         i_draw_y,
    output logic               o_in_board,
    output logic               o_in_frame,
    output logic [c_row_w-1:0] o_row,
    output logic [c_col_w-1:0] o_col,
    output logic [c_sub_w-1:0] o_sub_x,
    output logic [c_sub_w-1:0] o_sub_y
);

    localparam int c_board_w = COLS * CELL_PX;
    localparam int c_board_h = ROWS * CELL_PX;

    logic signed [10:0] w_off_x;
    logic signed [10:0] w_off_y;
    logic               w_in_x;
    logic               w_in_y;
    logic               w_ring_x;
    logic               w_ring_y;
    logic [8:0]         w_ox;
    logic [8:0]         w_oy;
    logic [17:0]        w_prod_x;
    logic [17:0]        w_prod_y;
    logic [8:0]         w_sub_x_full;
    logic [8:0]         w_sub_y_full;
    logic               w_unused;

    assign w_off_x = $signed({1'b0, i_draw_x}) - $signed(11'(BOARD_X0));
    assign w_off_y = $signed({1'b0, i_draw_y}) - $signed(11'(BOARD_Y0));

    assign w_in_x   = (w_off_x >= 11'sd0) && (w_off_x < $signed(11'(c_board_w)));
    assign w_in_y   = (w_off_y >= 11'sd0) && (w_off_y < $signed(11'(c_board_h)));
    assign w_ring_x = (w_off_x >= -$signed(11'(FRAME_PX)))
                   && (w_off_x < $signed(11'(c_board_w + FRAME_PX)));
    assign w_ring_y = (w_off_y >= -$signed(11'(FRAME_PX)))
                   && (w_off_y < $signed(11'(c_board_h + FRAME_PX)));

    assign o_in_board = w_in_x && w_in_y;
    assign o_in_frame = w_ring_x && w_ring_y && !o_in_board;

    // Row/col are only meaningful inside the board, where offsets fit 9 bits.
    assign w_ox     = w_off_x[8:0];
    assign w_oy     = w_off_y[8:0];
    assign w_prod_x = 18'(w_ox) * 18'(c_div_mul);
    assign w_prod_y = 18'(w_oy) * 18'(c_div_mul);
    assign o_col    = w_prod_x[c_div_shift +: c_col_w];
    assign o_row    = w_prod_y[c_div_shift +: c_row_w];

    assign w_sub_x_full = w_ox - 9'(o_col) * 9'(CELL_PX);
    assign w_sub_y_full = w_oy - 9'(o_row) * 9'(CELL_PX);
    assign o_sub_x      = w_sub_x_full[c_sub_w-1:0];
    assign o_sub_y      = w_sub_y_full[c_sub_w-1:0];

    assign w_unused = ^{w_prod_x[c_div_shift-1:0], w_prod_x[17:c_div_shift+c_col_w],
                        w_prod_y[c_div_shift-1:0], w_prod_y[17:c_div_shift+c_row_w],
                        w_sub_x_full[8:c_sub_w], w_sub_y_full[8:c_sub_w]};

endmodule

`default_nettype wire

// File: rtl/tetris_pixel_renderer.sv
// ============================================================================
// Module      : tetris_pixel_renderer
// Description : Two-stage pixel pipeline producing palette codes for the
//               playfield, falling piece, frame ring and grid shading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_pixel_renderer
    import tetris_pkg::*;
#(
    parameter int BOARD_X0 = c_board_x0,
    parameter int BOARD_Y0 = c_board_y0,
    parameter int CELL_PX  = c_cell_px,
    parameter int COLS     = c_cols,
    parameter int ROWS     = c_rows,
    parameter int FRAME_PX = c_frame_px
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic        piece_en,
    input  logic [4:0]  piece_col,
    input  logic [5:0]  piece_row,
    input  logic [15:0] piece_mask,
    input  logic [3:0]  piece_color,
    output logic        board_rd,
    output logic [7:0]  board_addr,
    input  logic [3:0]  board_data,
    output logic [3:0]  color,
    output logic        color_valid
);

    logic                w_in_board;
    logic                w_in_frame;
    logic [c_row_w-1:0]  w_row;
    logic [c_col_w-1:0]  w_col;
    logic [c_sub_w-1:0]  w_sub_x;
    logic [c_sub_w-1:0]  w_sub_y;

    tetris_cell_locator #(
        .BOARD_X0 (BOARD_X0),
        .BOARD_Y0 (BOARD_Y0),
        .CELL_PX  (CELL_PX),
        .COLS     (COLS),
        .ROWS     (ROWS),
        .FRAME_PX (FRAME_PX)
    ) u_locator (
        .i_draw_x   (DrawX),
        .i_draw_y   (DrawY),
        .o_in_board (w_in_board),
        .o_in_frame (w_in_frame),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_sub_x    (w_sub_x),
        .o_sub_y    (w_sub_y)
    );

    logic        r_pc_en;
    logic [4:0]  r_pc_col;
    logic [5:0]  r_pc_row;
    logic [15:0] r_pc_mask;
    logic [3:0]  r_pc_color;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc_en    <= 1'b0;
            r_pc_col   <= '0;
            r_pc_row   <= '0;
            r_pc_mask  <= '0;
            r_pc_color <= '0;
        end else if (frame_start) begin
            r_pc_en    <= piece_en;
            r_pc_col   <= piece_col;
            r_pc_row   <= piece_row;
            r_pc_mask  <= piece_mask;
            r_pc_color <= piece_color;
        end
    end

    // Hit test runs against the shadow seen at acceptance time, so a pixel
    // sharing its cycle with frame_start still uses the old piece.
    logic signed [6:0] w_dr;
    logic signed [6:0] w_dc;
    logic              w_hit;
    logic              w_edge;
    logic              w_rd;
    logic [7:0]        w_addr;
    logic [7:0]        r_addr_hold;
    pixel_class_t      w_class;

    assign w_dr   = $signed({2'b00, w_row}) - $signed({r_pc_row[5], r_pc_row});
    assign w_dc   = $signed({3'b000, w_col}) - $signed({{2{r_pc_col[4]}}, r_pc_col});
    assign w_hit  = r_pc_en && (w_dr[6:2] == 5'd0) && (w_dc[6:2] == 5'd0)
                 && r_pc_mask[{w_dr[1:0], w_dc[1:0]}];
    assign w_edge = (w_sub_x == c_sub_w'(CELL_PX - 1)) || (w_sub_y == c_sub_w'(CELL_PX - 1));

    assign w_class = w_in_board ? PIX_CELL : (w_in_frame ? PIX_FRAME : PIX_BG);

    assign w_rd       = Reset && pix_valid && w_in_board;
    assign w_addr     = 8'(w_row) * 8'(COLS) + 8'(w_col);
    assign board_rd   = w_rd;
    assign board_addr = w_rd ? w_addr : r_addr_hold;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_addr_hold <= '0;
        end else if (w_rd) begin
            r_addr_hold <= w_addr;
        end
    end

    logic         r_s1_valid;
    pixel_class_t r_s1_class;
    logic         r_s1_edge;
    logic         r_s1_hit;
    logic [3:0]   r_s1_pcolor;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_class  <= PIX_BG;
            r_s1_edge   <= 1'b0;
            r_s1_hit    <= 1'b0;
            r_s1_pcolor <= '0;
        end else begin
            r_s1_valid  <= pix_valid;
            r_s1_class  <= w_class;
            r_s1_edge   <= w_edge;
            r_s1_hit    <= w_hit;
            r_s1_pcolor <= r_pc_color;
        end
    end

    logic [3:0] w_color_next;

    always_comb begin
        w_color_next = c_color_bg;
        case (r_s1_class)
            PIX_FRAME: w_color_next = c_color_frame;
            PIX_CELL: begin
                if (r_s1_hit) begin
                    w_color_next = r_s1_edge ? c_color_edge : r_s1_pcolor;
                end else if (board_data != c_color_empty) begin
                    w_color_next = r_s1_edge ? c_color_edge : board_data;
                end else begin
                    w_color_next = r_s1_edge ? c_color_grid : c_color_empty;
                end
            end
            default: w_color_next = c_color_bg;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            color       <= c_color_bg;
            color_valid <= 1'b0;
        end else begin
            color_valid <= r_s1_valid;
            if (r_s1_valid) begin
                color <= w_color_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tetris_pixel_renderer.sv
// ============================================================================
// Module      : tb_tetris_pixel_renderer
// Description : Scoreboard bench for the Tetris pixel renderer with a
//               one-cycle-latency board RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tetris_pixel_renderer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        frame_start = 1'b0;
    logic        piece_en = 1'b0;
    logic [4:0]  piece_col = '0;
    logic [5:0]  piece_row = '0;
    logic [15:0] piece_mask = '0;
    logic [3:0]  piece_color = '0;
    logic        board_rd;
    logic [7:0]  board_addr;
    logic [3:0]  board_data = '0;
    logic [3:0]  color;
    logic        color_valid;

    tetris_pixel_renderer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_valid   (pix_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .piece_en    (piece_en),
        .piece_col   (piece_col),
        .piece_row   (piece_row),
        .piece_mask  (piece_mask),
        .piece_color (piece_color),
        .board_rd    (board_rd),
        .board_addr  (board_addr),
        .board_data  (board_data),
        .color       (color),
        .color_valid (color_valid)
    );

    always #5 Clk = ~Clk;

    logic [3:0] mem [0:199];

    always @(posedge Clk) begin
        if (board_rd && board_addr < 8'd200) board_data <= mem[board_addr];
    end

    typedef struct {
        bit          v;
        int          x;
        int          y;
        bit          fs;
        logic [4:0]  pcol;
        logic [5:0]  prow;
        logic [15:0] mask;
        logic [3:0]  exp;
        bit          rd;
        int          addr;
    } pix_t;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] sb[$];
    logic [3:0] last_color;

    function automatic pix_t mk(bit v, int x, int y, bit fs, logic [4:0] pcol, logic [5:0] prow,
                                logic [15:0] mask, logic [3:0] exp, bit rd, int addr);
        pix_t p;
        p.v = v; p.x = x; p.y = y; p.fs = fs; p.pcol = pcol; p.prow = prow;
        p.mask = mask; p.exp = exp; p.rd = rd; p.addr = addr;
        return p;
    endfunction

    function automatic pix_t px(int x, int y, logic [3:0] exp, bit rd, int addr);
        return mk(1'b1, x, y, 1'b0, 5'd0, 6'd0, 16'h0, exp, rd, addr);
    endfunction

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (color !== 4'hf || color_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs color=%h valid=%b want f/0", color, color_valid);
        end
        checks++;
        if (board_rd !== 1'b0 || board_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_board rd=%b addr=%0d want 0/0", board_rd, board_addr);
        end
        Reset = 1'b1;
        @(negedge Clk);
        DrawX = 10'd0; DrawY = 10'd0; pix_valid = 1'b1;
        #1;
        checks++;
        if (board_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_origin_rd got %b want 0", board_rd);
        end
        @(negedge Clk);
        pix_valid = 1'b0;
        checks++;
        if (color_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency_early valid=%b want 0", color_valid);
        end
        @(negedge Clk);
        checks++;
        if (color_valid !== 1'b1 || color !== 4'hf) begin
            errors++;
            $display("FAIL reset_origin color=%h valid=%b want f/1", color, color_valid);
        end
        @(negedge Clk);
        checks++;
        if (color_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_origin_tail valid=%b want 0", color_valid);
        end
        last_color = 4'hf;
    endtask

    task automatic test_frame_bg();
        pix_t t[$];
        pix_t e;
        logic [3:0] exp;
        t.push_back(px(218, 100, 4'he, 0, 0));
        t.push_back(px(423, 443, 4'he, 0, 0));
        t.push_back(px(424, 443, 4'hf, 0, 0));
        t.push_back(px(216, 36,  4'he, 0, 0));
        t.push_back(px(215, 36,  4'hf, 0, 0));
        t.push_back(px(216, 35,  4'hf, 0, 0));
        t.push_back(px(300, 444, 4'hf, 0, 0));
        for (int i = 0; i < t.size() + 2; i++) begin
            @(negedge Clk);
            checks++;
            if (color_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL frame_bg unexpected valid color=%h", color);
                end else begin
                    exp = sb.pop_front();
                    if (color !== exp) begin
                        errors++;
                        $display("FAIL frame_bg color got %h want %h", color, exp);
                    end
                    last_color = exp;
                end
            end else if (color !== last_color) begin
                errors++;
                $display("FAIL frame_bg idle color got %h want %h", color, last_color);
            end
            if (i < t.size()) begin
                e = t[i];
                pix_valid = e.v; DrawX = 10'(e.x); DrawY = 10'(e.y); frame_start = e.fs;
                piece_col = e.pcol; piece_row = e.prow; piece_mask = e.mask;
                if (e.v) sb.push_back(e.exp);
                #1;
                checks++;
                if (board_rd !== (e.v & e.rd) || (e.v && e.rd && board_addr !== 8'(e.addr))) begin
                    errors++;
                    $display("FAIL frame_bg rd/addr got %b/%0d want %b/%0d", board_rd, board_addr, e.rd, e.addr);
                end
            end else begin
                pix_valid = 1'b0; frame_start = 1'b0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL frame_bg missing outputs got 0 want %0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_cells();
        pix_t t[$];
        pix_t e;
        logic [3:0] exp;
        t.push_back(px(230, 50,  4'h0, 1, 0));
        t.push_back(px(239, 50,  4'hc, 1, 0));
        t.push_back(px(405, 425, 4'h3, 1, 199));
        t.push_back(px(419, 439, 4'hd, 1, 199));
        t.push_back(px(300, 100, 4'h7, 1, 34));
        t.push_back(px(319, 119, 4'hd, 1, 34));
        t.push_back(px(220, 40,  4'h0, 1, 0));
        for (int i = 0; i < t.size() + 2; i++) begin
            @(negedge Clk);
            checks++;
            if (color_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL cells unexpected valid color=%h", color);
                end else begin
                    exp = sb.pop_front();
                    if (color !== exp) begin
                        errors++;
                        $display("FAIL cells color got %h want %h", color, exp);
                    end
                    last_color = exp;
                end
            end else if (color !== last_color) begin
                errors++;
                $display("FAIL cells idle color got %h want %h", color, last_color);
            end
            if (i < t.size()) begin
                e = t[i];
                pix_valid = e.v; DrawX = 10'(e.x); DrawY = 10'(e.y); frame_start = e.fs;
                piece_col = e.pcol; piece_row = e.prow; piece_mask = e.mask;
                if (e.v) sb.push_back(e.exp);
                #1;
                checks++;
                if (board_rd !== (e.v & e.rd) || (e.v && e.rd && board_addr !== 8'(e.addr))) begin
                    errors++;
                    $display("FAIL cells rd/addr got %b/%0d want %b/%0d", board_rd, board_addr, e.rd, e.addr);
                end
            end else begin
                pix_valid = 1'b0; frame_start = 1'b0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL cells missing outputs got 0 want %0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        pix_t t[$];
        pix_t e;
        logic [3:0] exp;
        t.push_back(px(405, 425, 4'h3, 1, 199));
        t.push_back(mk(0, 230, 50, 0, 5'd0, 6'd0, 16'h0, 4'h0, 1, 0));
        t.push_back(px(300, 100, 4'h7, 1, 34));
        t.push_back(mk(0, 0, 0, 0, 5'd0, 6'd0, 16'h0, 4'h0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 5'd0, 6'd0, 16'h0, 4'h0, 0, 0));
        t.push_back(px(239, 50,  4'hc, 1, 0));
        t.push_back(px(218, 300, 4'he, 0, 0));
        t.push_back(px(419, 439, 4'hd, 1, 199));
        t.push_back(px(10, 10,   4'hf, 0, 0));
        for (int i = 0; i < t.size() + 2; i++) begin
            @(negedge Clk);
            checks++;
            if (color_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL back_to_back unexpected valid color=%h", color);
                end else begin
                    exp = sb.pop_front();
                    if (color !== exp) begin
                        errors++;
                        $display("FAIL back_to_back color got %h want %h", color, exp);
                    end
                    last_color = exp;
                end
            end else if (color !== last_color) begin
                errors++;
                $display("FAIL back_to_back idle color got %h want %h", color, last_color);
            end
            if (i < t.size()) begin
                e = t[i];
                pix_valid = e.v; DrawX = 10'(e.x); DrawY = 10'(e.y); frame_start = e.fs;
                piece_col = e.pcol; piece_row = e.prow; piece_mask = e.mask;
                if (e.v) sb.push_back(e.exp);
                #1;
                checks++;
                if (board_rd !== (e.v & e.rd) || (e.v && e.rd && board_addr !== 8'(e.addr))) begin
                    errors++;
                    $display("FAIL back_to_back rd/addr got %b/%0d want %b/%0d", board_rd, board_addr, e.v & e.rd, e.addr);
                end
            end else begin
                pix_valid = 1'b0; frame_start = 1'b0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back missing outputs got 0 want %0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_piece_overlay();
        pix_t t[$];
        pix_t e;
        logic [3:0] exp;
        mem[0] = 4'h3;
        piece_en = 1'b1; piece_color = 4'h5;
        t.push_back(mk(0, 0,   0,  1, 5'd0, 6'd0, 16'h0001, 4'h0, 0, 0));
        t.push_back(mk(1, 230, 50, 0, 5'd0, 6'd0, 16'h0000, 4'h5, 1, 0));
        t.push_back(mk(1, 239, 59, 0, 5'd0, 6'd0, 16'h0000, 4'hd, 1, 0));
        t.push_back(mk(1, 250, 50, 0, 5'd0, 6'd0, 16'h0000, 4'h0, 1, 1));
        t.push_back(mk(1, 230, 50, 1, 5'd0, 6'd0, 16'h0000, 4'h5, 1, 0));
        t.push_back(mk(1, 230, 50, 0, 5'd0, 6'd0, 16'h0000, 4'h3, 1, 0));
        t.push_back(mk(1, 230, 50, 1, 5'd0, 6'd0, 16'h0001, 4'h3, 1, 0));
        t.push_back(mk(1, 230, 50, 0, 5'd0, 6'd0, 16'h0000, 4'h5, 1, 0));
        for (int i = 0; i < t.size() + 2; i++) begin
            @(negedge Clk);
            checks++;
            if (color_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL piece unexpected valid color=%h", color);
                end else begin
                    exp = sb.pop_front();
                    if (color !== exp) begin
                        errors++;
                        $display("FAIL piece color got %h want %h", color, exp);
                    end
                    last_color = exp;
                end
            end else if (color !== last_color) begin
                errors++;
                $display("FAIL piece idle color got %h want %h", color, last_color);
            end
            if (i < t.size()) begin
                e = t[i];
                pix_valid = e.v; DrawX = 10'(e.x); DrawY = 10'(e.y); frame_start = e.fs;
                piece_col = e.pcol; piece_row = e.prow; piece_mask = e.mask;
                if (e.v) sb.push_back(e.exp);
                #1;
                checks++;
                if (board_rd !== (e.v & e.rd) || (e.v && e.rd && board_addr !== 8'(e.addr))) begin
                    errors++;
                    $display("FAIL piece rd/addr got %b/%0d want %b/%0d", board_rd, board_addr, e.v & e.rd, e.addr);
                end
            end else begin
                pix_valid = 1'b0; frame_start = 1'b0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL piece missing outputs got 0 want %0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_negative_origin();
        pix_t t[$];
        pix_t e;
        logic [3:0] exp;
        piece_en = 1'b1; piece_color = 4'h9;
        t.push_back(mk(0, 0,   0,  1, 5'h1f, 6'd0,  16'h0003, 4'h0, 0, 0));
        t.push_back(mk(1, 230, 50, 0, 5'h1f, 6'd0,  16'h0003, 4'h9, 1, 0));
        t.push_back(mk(1, 250, 50, 0, 5'h1f, 6'd0,  16'h0003, 4'h0, 1, 1));
        t.push_back(mk(1, 218, 50, 0, 5'h1f, 6'd0,  16'h0003, 4'he, 0, 0));
        t.push_back(mk(1, 230, 50, 1, 5'h1f, 6'h3f, 16'h0020, 4'h9, 1, 0));
        t.push_back(mk(1, 230, 70, 0, 5'h1f, 6'h3f, 16'h0020, 4'h0, 1, 10));
        t.push_back(mk(1, 230, 50, 0, 5'h1f, 6'h3f, 16'h0020, 4'h9, 1, 0));
        for (int i = 0; i < t.size() + 2; i++) begin
            @(negedge Clk);
            checks++;
            if (color_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL neg_origin unexpected valid color=%h", color);
                end else begin
                    exp = sb.pop_front();
                    if (color !== exp) begin
                        errors++;
                        $display("FAIL neg_origin color got %h want %h", color, exp);
                    end
                    last_color = exp;
                end
            end else if (color !== last_color) begin
                errors++;
                $display("FAIL neg_origin idle color got %h want %h", color, last_color);
            end
            if (i < t.size()) begin
                e = t[i];
                pix_valid = e.v; DrawX = 10'(e.x); DrawY = 10'(e.y); frame_start = e.fs;
                piece_col = e.pcol; piece_row = e.prow; piece_mask = e.mask;
                if (e.v) sb.push_back(e.exp);
                #1;
                checks++;
                if (board_rd !== (e.v & e.rd) || (e.v && e.rd && board_addr !== 8'(e.addr))) begin
                    errors++;
                    $display("FAIL neg_origin rd/addr got %b/%0d want %b/%0d", board_rd, board_addr, e.v & e.rd, e.addr);
                end
            end else begin
                pix_valid = 1'b0; frame_start = 1'b0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL neg_origin missing outputs got 0 want %0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge Clk);
        DrawX = 10'd230; DrawY = 10'd50; pix_valid = 1'b1;
        @(negedge Clk);
        DrawX = 10'd405; DrawY = 10'd425;
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (color_valid !== 1'b0 || color !== 4'hf) begin
            errors++;
            $display("FAIL midreset_immediate color=%h valid=%b want f/0", color, color_valid);
        end
        @(negedge Clk);
        pix_valid = 1'b0;
        checks++;
        if (color_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_held valid=%b want 0", color_valid);
        end
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (color_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale cycle %0d valid=%b want 0", i, color_valid);
            end
        end
        DrawX = 10'd405; DrawY = 10'd425; pix_valid = 1'b1;
        @(negedge Clk);
        pix_valid = 1'b0;
        checks++;
        if (color_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_early valid=%b want 0", color_valid);
        end
        @(negedge Clk);
        checks++;
        if (color_valid !== 1'b1 || color !== 4'h3) begin
            errors++;
            $display("FAIL midreset_resume color=%h valid=%b want 3/1", color, color_valid);
        end
        last_color = 4'h3;
    endtask

    initial begin
        for (int i = 0; i < 200; i++) mem[i] = 4'h0;
        mem[199] = 4'h3;
        mem[34]  = 4'h7;
        last_color = 4'hf;
        test_reset();
        test_frame_bg();
        test_cells();
        test_back_to_back();
        test_piece_overlay();
        test_negative_origin();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
